ball_move_ctrl: RTL and testbench
=================================

BALL_MOVE_CTRL -- requirements
Module: ball_move_ctrl

Interface
REQ-001 Parameter CLK_FREQUENCY_HZ, default 100000000: system clock rate.
REQ-002 Parameter UPDATE_FREQUENCY_HZ, default 5: move-attempt rate.
REQ-003 Parameter SIMULATE, default 0: when 1, the tick period is SIMULATE_FREQUENCY_CNT+1 cycles.
REQ-004 Parameter SIMULATE_FREQUENCY_CNT, default 5: simulation tick terminal count.
REQ-005 Parameter X_MAX / Y_MAX, default 8'd159 / 8'd119: largest legal coordinate.
REQ-006 Parameter START_X / START_Y, default 8'd1 / 8'd1: reset position.
REQ-007 Parameter ACK_TIMEOUT, default 16: maximum cycles to wait for map_ack.
REQ-008 clk  in  1  system clock; all state on rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 x_increment, x_decrement, y_increment, y_decrement  in  1 each  tilt direction requests, level-sensitive.
REQ-011 map_req  out  1  map read strobe, held until ack or timeout.
REQ-012 map_addr  out  16  {y_cand, x_cand}, stable while map_req is high.
REQ-013 map_ack  in  1  map data valid, one-cycle pulse.
REQ-014 map_wall  in  1  1 = addressed cell blocked; sampled only with map_ack.
REQ-015 x_out, y_out  out  8 each  committed ball position.
REQ-016 busy  out  1  high whenever state != IDLE.
REQ-017 move_done  out  1  one-cycle pulse when an attempt sequence ends.
REQ-018 blocked  out  1  one-cycle pulse per rejected axis move.
REQ-019 tick_overrun  out  1  one-cycle pulse when a tick arrives while busy.

Function
REQ-020 Tick: free-running counter; a one-cycle tick fires at top_cnt = SIMULATE ? SIMULATE_FREQUENCY_CNT : CLK_FREQUENCY_HZ/UPDATE_FREQUENCY_HZ-1, after which the counter clears.
REQ-021 FSM states: IDLE, X_REQ, X_WAIT, Y_REQ, Y_WAIT, DONE.
REQ-022 IDLE + tick: latch all four direction inputs into dir_q; go to X_REQ; later input changes are ignored until the next tick.
REQ-023 X_REQ: x_cand = x_out+1 for inc-only, x_out-1 for dec-only; with both or neither asserted, skip to Y_REQ with no map access.
REQ-024 Boundary: a decrement at 0 or an increment at X_MAX (Y_MAX for Y) skips lookup, pulses blocked, and proceeds to the next axis.
REQ-025 X_REQ with a legal candidate: assert map_req with map_addr = {y_out, x_cand}; go to X_WAIT.
REQ-026 X_WAIT: on map_ack, map_wall=0 commits x_out <= x_cand on the next edge, and map_wall=1 pulses blocked; then go to Y_REQ.
REQ-027 Timeout: if map_ack is absent for ACK_TIMEOUT cycles in a WAIT state, treat the move as blocked and drop map_req.
REQ-028 Y_REQ / Y_WAIT mirror X, using map_addr = {y_cand, x_out}, where x_out is the already-updated value, so the X move takes effect first.
REQ-029 DONE: pulse move_done for one cycle, then go to IDLE; a full attempt with two lookups and single-cycle ack takes 6 cycles after the tick.
REQ-030 A tick while busy is dropped and pulses tick_overrun; an attempt is never queued.
REQ-031 map_ack outside a WAIT state is ignored.
REQ-032 Coordinates never wrap: no arithmetic outside 0..MAX is ever committed.

Reset
REQ-033 reset asynchronously forces: state IDLE; tick counter 0; x_out=START_X; y_out=START_Y; map_req, map_addr, busy, move_done, blocked, and tick_overrun to 0.
REQ-034 Reset mid-lookup abandons the lookup; a late map_ack after reset is ignored per REQ-031.

Configuration
REQ-035 Macro BALL_BLOCK_CNT_EN, when defined, adds output blocked_cnt [7:0]: it increments on every blocked pulse, saturates at 255, and reset clears it to 0.
REQ-036 When BALL_BLOCK_CNT_EN is undefined, the port and counter are absent and all other behaviour is identical.

Structure
REQ-037 Package ball_pkg holds the state enum, COORD_W=8, and the MAP_ADDR_W=16 constant.
REQ-038 Sub-module ball_tick_gen holds the tick counter of REQ-020; the FSM and datapath stay in ball_move_ctrl.

Verification
REQ-039 SIMULATE=1, x_increment=1, map_wall=0, ack one cycle after req -> map_addr=16'h0102, x_out 1->2, move_done pulses once.
REQ-040 y_decrement=1, map_wall=1 -> y_out stays 1, blocked pulses once, move_done pulses.
REQ-041 Position (0,0) with x_decrement=1 -> no map_req, blocked pulses, x_out=0; x_increment and x_decrement both high -> no X lookup, no blocked pulse.
REQ-042 Map never acks -> map_req drops after 16 cycles, blocked pulses, position unchanged, FSM returns to IDLE.
REQ-043 Delay ack so the next tick lands in X_WAIT -> tick_overrun pulses and exactly one move_done follows.
REQ-044 Assert reset during Y_WAIT, then send a stray map_ack -> x_out=1, y_out=1, busy=0, no commit; with BALL_BLOCK_CNT_EN defined, 300 blocked moves give blocked_cnt=255.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared types, widths and the per-axis move resolver for the ball movement controller.
package ball_pkg;

  localparam int COORD_W    = 8;
  localparam int MAP_ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    X_REQ  = 3'd1,
    X_WAIT = 3'd2,
    Y_REQ  = 3'd3,
    Y_WAIT = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic x_inc;
    logic x_dec;
    logic y_inc;
    logic y_dec;
  } dir_t;

  typedef struct packed {
    logic               lookup;
    logic               blocked;
    logic [COORD_W-1:0] cand;
  } step_t;

  // Opposing or absent requests do nothing; a step past either edge is rejected without a lookup.
  function automatic step_t axis_step(input logic [COORD_W-1:0] pos, input logic inc,
                                      input logic dec, input logic [COORD_W-1:0] max_pos);
    step_t s;
    s.lookup  = 1'b0;
    s.blocked = 1'b0;
    s.cand    = pos;
    if (inc && !dec) begin
      if (pos == max_pos) begin
        s.blocked = 1'b1;
      end else begin
        s.lookup = 1'b1;
        s.cand   = pos + 8'd1;
      end
    end else if (dec && !inc) begin
      if (pos == 8'd0) begin
        s.blocked = 1'b1;
      end else begin
        s.lookup = 1'b1;
        s.cand   = pos - 8'd1;
      end
    end else begin
      s.lookup = 1'b0;
    end
    return s;
  endfunction

endpackage

// File: rtl/ball_move_ctrl_if.sv
// Map lookup handshake between the movement controller (master) and the wall map (slave).
interface ball_move_ctrl_if;
  import ball_pkg::*;

  logic                  map_req;
  logic [MAP_ADDR_W-1:0] map_addr;
  logic                  map_ack;
  logic                  map_wall;

  modport master (output map_req, output map_addr, input map_ack, input map_wall);
  modport slave  (input map_req, input map_addr, output map_ack, output map_wall);

endinterface

// File: rtl/ball_tick_gen.sv
// Free-running move-attempt tick: one registered pulse every TOP_CNT+1 clock cycles.
module ball_tick_gen #(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 5,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int TOP_CNT = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                           : (CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ) - 1;

  logic [31:0] cnt_r;
  logic [31:0] cnt_next_s;
  logic        tick_r;
  logic        tick_next_s;

  // Wrap the counter at the terminal count and flag the wrap.
  always_comb begin
    cnt_next_s  = cnt_r + 32'd1;
    tick_next_s = 1'b0;
    if (cnt_r == 32'(TOP_CNT)) begin
      cnt_next_s  = 32'd0;
      tick_next_s = 1'b1;
    end else begin
      tick_next_s = 1'b0;
    end
  end

  // Counter and tick registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= 32'd0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_next_s;
      tick_r <= tick_next_s;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/ball_move_ctrl.sv
// Ball position controller: on each tick, tries an X step then a Y step, each gated by a wall lookup.
// Define BALL_BLOCK_CNT_EN to add the saturating blocked_cnt output.
module ball_move_ctrl
  import ball_pkg::*;
#(
  parameter int                 CLK_FREQUENCY_HZ       = 100000000,
  parameter int                 UPDATE_FREQUENCY_HZ    = 5,
  parameter int                 SIMULATE               = 0,
  parameter int                 SIMULATE_FREQUENCY_CNT = 5,
  parameter logic [COORD_W-1:0] X_MAX                  = 8'd159,
  parameter logic [COORD_W-1:0] Y_MAX                  = 8'd119,
  parameter logic [COORD_W-1:0] START_X                = 8'd1,
  parameter logic [COORD_W-1:0] START_Y                = 8'd1,
  parameter int                 ACK_TIMEOUT            = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_increment,
  input  logic               x_decrement,
  input  logic               y_increment,
  input  logic               y_decrement,
  ball_move_ctrl_if.master   map_bus,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               busy,
  output logic               move_done,
  output logic               blocked,
  output logic               tick_overrun
`ifdef BALL_BLOCK_CNT_EN
  ,
  output logic [7:0]         blocked_cnt
`endif
);

  logic                  tick_s;
  state_t                state_r, state_next_s;
  dir_t                  dir_r, dir_next_s;
  logic [COORD_W-1:0]    x_r, x_next_s, y_r, y_next_s, cand_r, cand_next_s;
  logic [15:0]           wait_r, wait_next_s;
  logic                  req_r, req_next_s;
  logic [MAP_ADDR_W-1:0] addr_r, addr_next_s;
  logic                  blocked_r, blocked_next_s;
  logic                  busy_r, done_r, overrun_r;
  step_t                 xs_s, ys_s;

  ball_tick_gen #(
    .CLK_FREQUENCY_HZ      (CLK_FREQUENCY_HZ),
    .UPDATE_FREQUENCY_HZ   (UPDATE_FREQUENCY_HZ),
    .SIMULATE              (SIMULATE),
    .SIMULATE_FREQUENCY_CNT(SIMULATE_FREQUENCY_CNT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

  // Next-state and datapath decisions; Y uses the already-committed x_r so X takes effect first.
  always_comb begin
    state_next_s   = state_r;
    dir_next_s     = dir_r;
    x_next_s       = x_r;
    y_next_s       = y_r;
    cand_next_s    = cand_r;
    wait_next_s    = wait_r;
    req_next_s     = req_r;
    addr_next_s    = addr_r;
    blocked_next_s = 1'b0;
    xs_s = axis_step(x_r, dir_r.x_inc, dir_r.x_dec, X_MAX);
    ys_s = axis_step(y_r, dir_r.y_inc, dir_r.y_dec, Y_MAX);
    case (state_r)
      IDLE: begin
        if (tick_s) begin
          dir_next_s   = '{x_inc: x_increment, x_dec: x_decrement,
                           y_inc: y_increment, y_dec: y_decrement};
          state_next_s = X_REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      X_REQ: begin
        if (xs_s.lookup) begin
          req_next_s   = 1'b1;
          addr_next_s  = {y_r, xs_s.cand};
          cand_next_s  = xs_s.cand;
          wait_next_s  = 16'd0;
          state_next_s = X_WAIT;
        end else begin
          blocked_next_s = xs_s.blocked;
          state_next_s   = Y_REQ;
        end
      end
      X_WAIT: begin
        if (map_bus.map_ack) begin
          req_next_s     = 1'b0;
          blocked_next_s = map_bus.map_wall;
          x_next_s       = map_bus.map_wall ? x_r : cand_r;
          state_next_s   = Y_REQ;
        end else if (wait_r == 16'(ACK_TIMEOUT - 1)) begin
          req_next_s     = 1'b0;
          blocked_next_s = 1'b1;
          state_next_s   = Y_REQ;
        end else begin
          wait_next_s = wait_r + 16'd1;
        end
      end
      Y_REQ: begin
        if (ys_s.lookup) begin
          req_next_s   = 1'b1;
          addr_next_s  = {ys_s.cand, x_r};
          cand_next_s  = ys_s.cand;
          wait_next_s  = 16'd0;
          state_next_s = Y_WAIT;
        end else begin
          blocked_next_s = ys_s.blocked;
          state_next_s   = DONE;
        end
      end
      Y_WAIT: begin
        if (map_bus.map_ack) begin
          req_next_s     = 1'b0;
          blocked_next_s = map_bus.map_wall;
          y_next_s       = map_bus.map_wall ? y_r : cand_r;
          state_next_s   = DONE;
        end else if (wait_r == 16'(ACK_TIMEOUT - 1)) begin
          req_next_s     = 1'b0;
          blocked_next_s = 1'b1;
          state_next_s   = DONE;
        end else begin
          wait_next_s = wait_r + 16'd1;
        end
      end
      DONE: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
        req_next_s   = 1'b0;
      end
    endcase
  end

  // State, position and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      dir_r     <= '0;
      x_r       <= START_X;
      y_r       <= START_Y;
      cand_r    <= 8'd0;
      wait_r    <= 16'd0;
      req_r     <= 1'b0;
      addr_r    <= 16'd0;
      blocked_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      dir_r     <= dir_next_s;
      x_r       <= x_next_s;
      y_r       <= y_next_s;
      cand_r    <= cand_next_s;
      wait_r    <= wait_next_s;
      req_r     <= req_next_s;
      addr_r    <= addr_next_s;
      blocked_r <= blocked_next_s;
      busy_r    <= (state_next_s != IDLE);
      done_r    <= (state_next_s == DONE);
      overrun_r <= tick_s && (state_r != IDLE);
    end
  end

`ifdef BALL_BLOCK_CNT_EN
  logic [7:0] blkcnt_r;

  // Saturating count of rejected axis moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blkcnt_r <= 8'd0;
    end else if (blocked_next_s && (blkcnt_r != 8'hFF)) begin
      blkcnt_r <= blkcnt_r + 8'd1;
    end else begin
      blkcnt_r <= blkcnt_r;
    end
  end

  assign blocked_cnt = blkcnt_r;
`endif

  assign map_bus.map_req  = req_r;
  assign map_bus.map_addr = addr_r;
  assign x_out            = x_r;
  assign y_out            = y_r;
  assign busy             = busy_r;
  assign move_done        = done_r;
  assign blocked          = blocked_r;
  assign tick_overrun     = overrun_r;

endmodule

// File: tb/tb_ball_move_ctrl.sv
// Self-checking bench for ball_move_ctrl: table of move attempts scored against a queue, plus reset/stray-ack
// and (with BALL_BLOCK_CNT_EN) blocked counter saturation sequences.
module tb_ball_move_ctrl;
  import ball_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       x_increment, x_decrement, y_increment, y_decrement;
  logic [7:0] x_out, y_out;
  logic       busy, move_done, blocked, tick_overrun;
`ifdef BALL_BLOCK_CNT_EN
  logic [7:0] blocked_cnt;
`endif

  ball_move_ctrl_if mif ();

  ball_move_ctrl #(
    .SIMULATE              (1),
    .SIMULATE_FREQUENCY_CNT(11),
    .X_MAX                 (8'd3),
    .Y_MAX                 (8'd2),
    .ACK_TIMEOUT           (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .x_increment (x_increment),
    .x_decrement (x_decrement),
    .y_increment (y_increment),
    .y_decrement (y_decrement),
    .map_bus     (mif),
    .x_out       (x_out),
    .y_out       (y_out),
    .busy        (busy),
    .move_done   (move_done),
    .blocked     (blocked),
    .tick_overrun(tick_overrun)
`ifdef BALL_BLOCK_CNT_EN
    ,
    .blocked_cnt (blocked_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dir;        // {x_inc, x_dec, y_inc, y_dec}
    int          ack_delay;  // -1: map never answers
    logic [7:0]  ex, ey;
    int          lookups, nblk, req_cyc, novr;
    logic [15:0] addr0;      // first lookup address, FFFF when none
  } vec_t;

  vec_t vecs[14];
  vec_t sb[$];
  vec_t mv;
  int   errors = 0, checks = 0;
  int   ack_delay = 0;
  bit   resp_en = 1'b1, stray_pulse = 1'b0, sb_on = 1'b1;
  int   c_lk = 0, c_blk = 0, c_req = 0, c_ovr = 0;
  logic [15:0] c_addr0 = 16'hFFFF;
  logic busy_d = 1'b0, req_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] dir, input int dly, input logic [7:0] ex,
                              input logic [7:0] ey, input int lk, input int blk, input int rq,
                              input int ovr, input logic [15:0] a0);
    vec_t v;
    v.dir = dir; v.ack_delay = dly; v.ex = ex; v.ey = ey;
    v.lookups = lk; v.nblk = blk; v.req_cyc = rq; v.novr = ovr; v.addr0 = a0;
    return v;
  endfunction

  function automatic logic wall_at(input logic [15:0] a);
    return (a == 16'h0002) || (a == 16'h0202);
  endfunction

  // Map model: answers requests from a fixed wall map after ack_delay cycles.
  initial begin : responder
    mif.map_ack  = 1'b0;
    mif.map_wall = 1'b0;
    forever begin
      @(negedge clk);
      if (stray_pulse) begin
        stray_pulse  = 1'b0;
        mif.map_wall = 1'b0;
        mif.map_ack  = 1'b1;
        @(negedge clk);
        mif.map_ack  = 1'b0;
      end else if (resp_en && mif.map_req === 1'b1) begin
        if (ack_delay >= 0) begin
          for (int i = 0; i < ack_delay; i++) @(negedge clk);
          mif.map_wall = wall_at(mif.map_addr);
          mif.map_ack  = 1'b1;
          @(negedge clk);
          mif.map_ack  = 1'b0;
          mif.map_wall = 1'b0;
        end else begin
          for (int i = 0; i < 100 && mif.map_req === 1'b1; i++) @(negedge clk);
        end
      end
    end
  end

  // Per-attempt activity counters; scored against the queue at move_done.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && busy_d !== 1'b1) begin
        c_lk = 0; c_blk = 0; c_req = 0; c_ovr = 0; c_addr0 = 16'hFFFF;
      end
      if (mif.map_req === 1'b1 && req_d !== 1'b1) begin
        if (c_lk == 0) c_addr0 = mif.map_addr;
        c_lk++;
      end
      if (mif.map_req === 1'b1) c_req++;
      if (blocked === 1'b1) c_blk++;
      if (tick_overrun === 1'b1) c_ovr++;
      if (move_done === 1'b1) begin
        if (sb_on) chk("sb_pending_at_done", (sb.size() > 0), 1'b1);
        if (sb.size() > 0) begin
          mv = sb.pop_front();
          chk("x_out", x_out, mv.ex);
          chk("y_out", y_out, mv.ey);
          chk("lookups", c_lk, mv.lookups);
          chk("blocked_pulses", c_blk, mv.nblk);
          chk("req_cycles", c_req, mv.req_cyc);
          chk("tick_overruns", c_ovr, mv.novr);
          chk("first_addr", c_addr0, mv.addr0);
        end
      end
      busy_d = busy;
      req_d  = mif.map_req;
    end
  end

  initial begin : main
    int n;
    reset = 1'b1;
    {x_increment, x_decrement, y_increment, y_decrement} = 4'b0000;
    // X_MAX=3, Y_MAX=2, start (1,1); walls at (2,0) and (2,2)
    vecs[0]  = mk(4'b1000,  0, 8'd2, 8'd1, 1, 0,  1, 0, 16'h0102);
    vecs[1]  = mk(4'b0001,  0, 8'd2, 8'd1, 1, 1,  1, 0, 16'h0002);
    vecs[2]  = mk(4'b1010,  0, 8'd3, 8'd2, 2, 0,  2, 0, 16'h0103);
    vecs[3]  = mk(4'b1010,  0, 8'd3, 8'd2, 0, 2,  0, 0, 16'hFFFF);
    vecs[4]  = mk(4'b0101,  0, 8'd3, 8'd1, 2, 1,  2, 0, 16'h0202);
    vecs[5]  = mk(4'b1111,  0, 8'd3, 8'd1, 0, 0,  0, 0, 16'hFFFF);
    vecs[6]  = mk(4'b0000,  0, 8'd3, 8'd1, 0, 0,  0, 0, 16'hFFFF);
    vecs[7]  = mk(4'b0100,  0, 8'd2, 8'd1, 1, 0,  1, 0, 16'h0102);
    vecs[8]  = mk(4'b0100,  0, 8'd1, 8'd1, 1, 0,  1, 0, 16'h0101);
    vecs[9]  = mk(4'b0101,  0, 8'd0, 8'd0, 2, 0,  2, 0, 16'h0100);
    vecs[10] = mk(4'b0101,  0, 8'd0, 8'd0, 0, 2,  0, 0, 16'hFFFF);
    vecs[11] = mk(4'b1100,  0, 8'd0, 8'd0, 0, 0,  0, 0, 16'hFFFF);
    vecs[12] = mk(4'b1000, -1, 8'd0, 8'd0, 1, 1, 16, 1, 16'h0001);
    vecs[13] = mk(4'b1000, 12, 8'd1, 8'd0, 1, 0, 13, 1, 16'h0001);

    repeat (3) @(negedge clk);
    chk("rst_x_out", x_out, 8'd1);
    chk("rst_y_out", y_out, 8'd1);
    chk("rst_map_req", mif.map_req, 1'b0);
    chk("rst_map_addr", mif.map_addr, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_move_done", move_done, 1'b0);
    chk("rst_blocked", blocked, 1'b0);
    chk("rst_tick_overrun", tick_overrun, 1'b0);
`ifdef BALL_BLOCK_CNT_EN
    chk("rst_blocked_cnt", blocked_cnt, 8'd0);
`endif
    {x_increment, x_decrement, y_increment, y_decrement} = vecs[0].dir;
    reset = 1'b0;

    for (int k = 0; k < 14; k++) begin
      ack_delay = vecs[k].ack_delay;
      {x_increment, x_decrement, y_increment, y_decrement} = vecs[k].dir;
      n = 0;
      while (busy !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk("attempt_start", busy, 1'b1);
      if (busy === 1'b1) sb.push_back(vecs[k]);
      // inputs must be ignored once latched
      {x_increment, x_decrement, y_increment, y_decrement} = 4'($urandom);
      n = 0;
      while (move_done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      chk("attempt_done", move_done, 1'b1);
      @(negedge clk);
      chk("idle_after_done", busy, 1'b0);
      chk("done_one_cycle", move_done, 1'b0);
      {x_increment, x_decrement, y_increment, y_decrement} = 4'b0000;
    end
    chk("sb_drained", sb.size(), 0);

    // Reset during Y_WAIT, then a stray ack
    sb_on = 1'b0;
    ack_delay = -1;
    {x_increment, x_decrement, y_increment, y_decrement} = 4'b0010;
    n = 0;
    while (mif.map_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("stray_y_req_seen", mif.map_addr, 16'h0101);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_x_out", x_out, 8'd1);
    chk("abort_y_out", y_out, 8'd1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_map_req", mif.map_req, 1'b0);
    {x_increment, x_decrement, y_increment, y_decrement} = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    stray_pulse = 1'b1;
    repeat (5) @(negedge clk);
    chk("stray_x_out", x_out, 8'd1);
    chk("stray_y_out", y_out, 8'd1);
    chk("stray_busy", busy, 1'b0);
    chk("stray_map_req", mif.map_req, 1'b0);

`ifdef BALL_BLOCK_CNT_EN
    reset = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    chk("cnt_after_reset", blocked_cnt, 8'd0);
    {x_increment, x_decrement, y_increment, y_decrement} = 4'b0101;
    reset = 1'b0;
    // first attempt walks to (0,0); each later one is blocked on both axes
    for (int a = 0; a < 151; a++) begin
      n = 0;
      while (move_done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      if (a == 127) chk("cnt_mid", blocked_cnt, 8'd254);
      @(negedge clk);
    end
    chk("cnt_saturated", blocked_cnt, 8'd255);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
